or1200_vlx_unpack: RTL and testbench

//  Variable-length bit extractor for the Huffman/JPEG decode path; inverse of the VLX bit packer.

---
 rtl/or1200_vlx_unpack.sv | 105 ++++++++++
 tb/tb_or1200_vlx_unpack.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/or1200_vlx_unpack.sv
// Variable-length MSB-first bit extractor for the OR1200 Huffman/JPEG decode path.
// Optional macro VLX_EXTEND_EN: val_o carries the JPEG EXTEND of each field.
module or1200_vlx_unpack #(
  parameter int unsigned BUF_W   = 64,
  parameter int unsigned MAX_GET = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] word_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  input  logic        get_i,
  input  logic [4:0]  get_len_i,
  input  logic        align_i,
  input  logic        flush_i,
  output logic [15:0] bits_o,
  output logic [16:0] val_o,
  output logic        bits_valid_o,
  output logic [15:0] peek_o,
  output logic [6:0]  avail_o,
  input  logic        spr_addr_i,
  output logic [31:0] spr_dat_o
);

  logic [BUF_W-1:0] r_buf;
  logic [6:0]       r_cnt;
  logic [15:0]      r_bits;
  logic [16:0]      r_val;
  logic             r_valid;

  logic             w_accept;
  logic             w_consume;
  logic             w_zero_get;
  logic [6:0]       w_len;
  logic [6:0]       w_used;
  logic [6:0]       w_rem;
  logic [15:0]      w_field;
  logic [16:0]      w_val;
  logic [BUF_W-1:0] w_buf_d;
  logic [6:0]       w_cnt_d;

  assign w_len        = {2'b00, get_len_i};
  assign word_ready_o = (r_cnt <= 7'd32);
  assign w_accept     = word_valid_i & word_ready_o & ~flush_i;
  assign w_consume    = get_i & (get_len_i != 5'd0) & (w_len <= 7'(MAX_GET)) &
                        (r_cnt >= w_len) & ~align_i & ~flush_i;
  assign w_zero_get   = get_i & (get_len_i == 5'd0) & ~align_i & ~flush_i;

  // Oldest bits sit at the top, so the field is the top len bits shifted down.
  assign w_field = r_buf[63:48] >> (5'd16 - get_len_i);

`ifdef VLX_EXTEND_EN
  logic [16:0] w_mask;
  assign w_mask = (17'd1 << get_len_i) - 17'd1;
  assign w_val  = r_buf[63] ? {1'b0, w_field} : ({1'b0, w_field} - w_mask);
`else
  assign w_val  = {1'b0, w_field};
`endif

  always_comb begin
    w_used = 7'd0;
    if (align_i && !flush_i) begin
      w_used = {4'd0, r_cnt[2:0]};
    end else if (w_consume) begin
      w_used = w_len;
    end
    w_rem   = r_cnt - w_used;
    // Accept only happens with cnt <= 32, so rem <= 32 and the new word always fits.
    w_buf_d = (r_buf << w_used) | (w_accept ? ({word_i, 32'b0} >> w_rem) : {BUF_W{1'b0}});
    w_cnt_d = w_rem + (w_accept ? 7'd32 : 7'd0);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_val   <= '0;
      r_valid <= 1'b0;
    end else if (flush_i) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_buf   <= w_buf_d;
      r_cnt   <= w_cnt_d;
      r_valid <= w_consume | w_zero_get;
      if (w_consume) begin
        r_bits <= w_field;
        r_val  <= w_val;
      end else if (w_zero_get) begin
        r_bits <= '0;
        r_val  <= '0;
      end
    end
  end

  assign bits_o       = r_bits;
  assign val_o        = r_val;
  assign bits_valid_o = r_valid;
  assign peek_o       = r_buf[63:48];
  assign avail_o      = r_cnt;
  assign spr_dat_o    = spr_addr_i ? r_buf[63:32] : {25'b0, r_cnt};

endmodule

// File: tb/tb_or1200_vlx_unpack.sv
// Bench for or1200_vlx_unpack: directed steps plus random traffic against a bit-queue model.
module tb_or1200_vlx_unpack;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] word_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic        get_i;
  logic [4:0]  get_len_i;
  logic        align_i;
  logic        flush_i;
  logic [15:0] bits_o;
  logic [16:0] val_o;
  logic        bits_valid_o;
  logic [15:0] peek_o;
  logic [6:0]  avail_o;
  logic        spr_addr_i;
  logic [31:0] spr_dat_o;

  int tests = 0;
  int fails = 0;

  bit          q[$];
  logic [15:0] m_bits;
  logic [16:0] m_val;

  always #5 clk_i = ~clk_i;

  or1200_vlx_unpack dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .get_i        (get_i),
    .get_len_i    (get_len_i),
    .align_i      (align_i),
    .flush_i      (flush_i),
    .bits_o       (bits_o),
    .val_o        (val_o),
    .bits_valid_o (bits_valid_o),
    .peek_o       (peek_o),
    .avail_o      (avail_o),
    .spr_addr_i   (spr_addr_i),
    .spr_dat_o    (spr_dat_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] extend(input logic [15:0] b, input int len);
    int v;
    if (len == 0) return 17'd0;
`ifdef VLX_EXTEND_EN
    if (b[len-1]) v = int'(b);
    else v = int'(b) - ((1 << len) - 1);
    return v[16:0];
`else
    v = int'(b);
    return v[16:0];
`endif
  endfunction

  function automatic logic [31:0] head(input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r[n-1-i] = (i < q.size()) ? q[i] : 1'b0;
    return r;
  endfunction

  task automatic check_state(input string tag, input logic exp_valid);
    chk({tag, ".valid"}, 64'(bits_valid_o), 64'(exp_valid));
    chk({tag, ".avail"}, 64'(avail_o), 64'(q.size()));
    chk({tag, ".peek"}, 64'(peek_o), 64'(head(16)));
    chk({tag, ".bits"}, 64'(bits_o), 64'(m_bits));
    chk({tag, ".val"}, 64'(val_o), 64'(m_val));
    chk({tag, ".spr"}, 64'(spr_dat_o), spr_addr_i ? 64'(head(32)) : 64'(q.size()));
  endtask

  // Called #1 after a rising edge; applies inputs for one cycle and checks the result.
  task automatic step(input string tag, input logic wv, input logic [31:0] w, input logic g,
                      input logic [4:0] len, input logic al, input logic fl);
    logic ev;
    logic rdy;
    word_valid_i = wv; word_i = w; get_i = g; get_len_i = len; align_i = al; flush_i = fl;
    spr_addr_i = 1'($urandom_range(0, 1));
    rdy = (q.size() <= 32);
    chk({tag, ".ready"}, 64'(word_ready_o), 64'(rdy));
    ev = 1'b0;
    if (fl) begin
      q.delete();
    end else if (al) begin
      repeat (q.size() % 8) void'(q.pop_front());
    end else if (g && len == 0) begin
      ev = 1'b1; m_bits = '0; m_val = '0;
    end else if (g && len <= 16 && q.size() >= int'(len)) begin
      ev = 1'b1; m_bits = '0;
      for (int i = 0; i < int'(len); i++) m_bits = {m_bits[14:0], q.pop_front()};
      m_val = extend(m_bits, int'(len));
    end
    if (wv && rdy && !fl) for (int i = 31; i >= 0; i--) q.push_back(w[i]);
    @(posedge clk_i); #1;
    check_state(tag, ev);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b0; word_i = 32'hDEADBEEF; word_valid_i = 1'b1; get_i = 1'b1;
    get_len_i = 5'd4; align_i = 1'b0; flush_i = 1'b0; spr_addr_i = 1'b0;
    m_bits = '0; m_val = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("t1.avail", 64'(avail_o), 64'd0);
    chk("t1.ready", 64'(word_ready_o), 64'd1);
    chk("t1.valid", 64'(bits_valid_o), 64'd0);
    chk("t1.peek", 64'(peek_o), 64'd0);
    chk("t1.bits", 64'(bits_o), 64'd0);
    rst_i = 1'b1;

    // T2: 0xA5F00000 pulled as 4, 4, 8 bits
    step("t2.push", 1'b1, 32'hA5F00000, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("t2.avail32", 64'(avail_o), 64'd32);
    step("t2.get4a", 1'b0, 32'h0, 1'b1, 5'd4, 1'b0, 1'b0);
    chk("t2.bitsA", 64'(bits_o), 64'hA);
    step("t2.get4b", 1'b0, 32'h0, 1'b1, 5'd4, 1'b0, 1'b0);
    chk("t2.bits5", 64'(bits_o), 64'h5);
    step("t2.get8", 1'b0, 32'h0, 1'b1, 5'd8, 1'b0, 1'b0);
    chk("t2.bitsF0", 64'(bits_o), 64'hF0);
    chk("t2.avail16", 64'(avail_o), 64'd16);

    // T3: simultaneous push and get 16 from avail 28
    step("t3.flush", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    step("t3.push", 1'b1, 32'hCAFEBABE, 1'b0, 5'd0, 1'b0, 1'b0);
    step("t3.get4", 1'b0, 32'h0, 1'b1, 5'd4, 1'b0, 1'b0);
    step("t3.both", 1'b1, 32'h12345678, 1'b1, 5'd16, 1'b0, 1'b0);
    chk("t3.bits", 64'(bits_o), 64'hAFEB);
    chk("t3.avail44", 64'(avail_o), 64'd44);
    chk("t3.peek", 64'(peek_o), 64'hABE1);

    // T4: stall with 3 bits, then a word arrives
    step("t4.get16", 1'b0, 32'h0, 1'b1, 5'd16, 1'b0, 1'b0);
    step("t4.get13", 1'b0, 32'h0, 1'b1, 5'd13, 1'b0, 1'b0);
    step("t4.get12", 1'b0, 32'h0, 1'b1, 5'd12, 1'b0, 1'b0);
    chk("t4.avail3", 64'(avail_o), 64'd3);
    step("t4.stall1", 1'b0, 32'h0, 1'b1, 5'd8, 1'b0, 1'b0);
    step("t4.stall2", 1'b0, 32'h0, 1'b1, 5'd8, 1'b0, 1'b0);
    step("t4.push", 1'b1, 32'hF00DF00D, 1'b1, 5'd8, 1'b0, 1'b0);
    step("t4.serve", 1'b0, 32'h0, 1'b1, 5'd8, 1'b0, 1'b0);
    chk("t4.bits", 64'(bits_o), 64'h1E);

    // T5: align from 45, align+get, flush with a word offered
    step("t5.flush", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    step("t5.pushA", 1'b1, 32'h0F0F0F0F, 1'b0, 5'd0, 1'b0, 1'b0);
    step("t5.pushB", 1'b1, 32'h3C3C3C3C, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("t5.full", 64'(word_ready_o), 64'd0);
    step("t5.get16", 1'b0, 32'h0, 1'b1, 5'd16, 1'b0, 1'b0);
    step("t5.get3", 1'b0, 32'h0, 1'b1, 5'd3, 1'b0, 1'b0);
    chk("t5.avail45", 64'(avail_o), 64'd45);
    step("t5.align", 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("t5.avail40", 64'(avail_o), 64'd40);
    step("t5.align_get", 1'b0, 32'h0, 1'b1, 5'd5, 1'b1, 1'b0);
    step("t5.get_after", 1'b0, 32'h0, 1'b1, 5'd5, 1'b0, 1'b0);
    step("t5.flush_push", 1'b1, 32'h55555555, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("t5.avail0", 64'(avail_o), 64'd0);

    // T6: EXTEND fields and a zero-length get
    step("t6.push", 1'b1, 32'h70000000, 1'b0, 5'd0, 1'b0, 1'b0);
    step("t6.f011", 1'b0, 32'h0, 1'b1, 5'd3, 1'b0, 1'b0);
    step("t6.f100", 1'b0, 32'h0, 1'b1, 5'd3, 1'b0, 1'b0);
    step("t6.len0", 1'b0, 32'h0, 1'b1, 5'd0, 1'b0, 1'b0);
    step("t6.flush", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    step("t6.pushF", 1'b1, 32'hFFFF0000, 1'b0, 5'd0, 1'b0, 1'b0);
    step("t6.fFFFF", 1'b0, 32'h0, 1'b1, 5'd16, 1'b0, 1'b0);
    chk("t6.bitsFFFF", 64'(bits_o), 64'hFFFF);
    chk("t6.valFFFF", 64'(val_o), 64'h0FFFF);
    idle("t6.idle");

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step("rnd", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0),
           5'($urandom_range(0, 16)), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 39) == 0));
    end

    // Reset mid-stream with a strobe pending
    step("rst.push", 1'b1, 32'h8BADF00D, 1'b0, 5'd0, 1'b0, 1'b0);
    step("rst.get", 1'b0, 32'h0, 1'b1, 5'd7, 1'b0, 1'b0);
    get_i = 1'b0;
    rst_i = 1'b0;
    #1;
    q.delete(); m_bits = '0; m_val = '0;
    check_state("rst", 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    idle("rst.idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
